// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshakes on both sides.
// Single-cycle ops (LUI, compares, add/sub, logic, shifts, popcount) land in
// DONE one cycle after acceptance. Unsigned multiply runs as a WIDTH-step
// shift-add loop in BUSY and lands in DONE WIDTH+1 cycles after acceptance.
//
// Handshake: an input is taken on any rising edge where in_valid && in_ready.
// A result is consumed on any rising edge where out_valid && out_ready; the
// result and flag are held unchanged until then. in_ready is high in IDLE and,
// in DONE, follows out_ready so a new op can replace a consumed result on the
// same edge (back-to-back).
module alu_seq #(
   parameter int WIDTH  = 32,
   parameter bit MUL_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             add_sub,
   input  logic             ConstVar,
   input  logic [1:0]       LogicFn,
   input  logic [1:0]       ShiftFn,
   input  logic [2:0]       FnClass,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] ALU_result,
   output logic             Overflow
);

   localparam int SHW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] WIDTH_V  = WIDTH'(WIDTH);
   localparam logic [SHW-1:0]   LAST_CNT = SHW'(WIDTH - 1);

   localparam logic [2:0] FN_LUI   = 3'b000;
   localparam logic [2:0] FN_SLT   = 3'b001;
   localparam logic [2:0] FN_SGT   = 3'b010;
   localparam logic [2:0] FN_ADD   = 3'b011;
   localparam logic [2:0] FN_LOGIC = 3'b100;
   localparam logic [2:0] FN_SHIFT = 3'b101;
   localparam logic [2:0] FN_HAM   = 3'b110;
   localparam logic [2:0] FN_MUL   = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             ovf_q, ovf_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;   // multiplicand (x)
   logic [WIDTH-1:0] mhi_q, mhi_d;       // upper half of running product
   logic [WIDTH-1:0] mlo_q, mlo_d;       // multiplier shifting out / lower product
   logic [SHW-1:0]   cnt_q, cnt_d;       // multiply step counter

   logic             accept;
   logic             is_mul;

   // single-cycle datapath signals
   logic [WIDTH-1:0]   op_res;
   logic               op_ovf;
   logic [WIDTH-1:0]   y_eff;
   logic [WIDTH-1:0]   sum;
   logic [WIDTH-1:0]   pop;
   logic [SHW-1:0]     sh;
   logic               sh_big;
   logic [2*WIDTH-1:0] rot2;

   // multiply step signals
   logic [WIDTH:0]     step_sum;
   logic [WIDTH-1:0]   step_hi;
   logic [WIDTH-1:0]   step_lo;

   assign in_ready   = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
   assign accept     = in_valid && in_ready;
   assign is_mul     = MUL_EN && (FnClass == FN_MUL);
   assign out_valid  = (state_q == S_DONE);
   assign ALU_result = result_q;
   assign Overflow   = ovf_q;

   // Single-cycle result and overflow for the op currently on the inputs.
   always_comb begin
      op_res = '0;
      op_ovf = 1'b0;
      y_eff  = add_sub ? ~y : y;
      sum    = x + y_eff + {{(WIDTH-1){1'b0}}, add_sub};
      pop    = '0;
      for (int i = 0; i < WIDTH; i++) begin
         pop = pop + {{(WIDTH-1){1'b0}}, x[i]};
      end
      // Constant-1 shifts can never saturate; variable shifts saturate on the
      // full-width amount, while rotate only looks at the low SHW bits.
      sh     = ConstVar ? SHW'(1) : y[SHW-1:0];
      sh_big = !ConstVar && (y >= WIDTH_V);
      rot2   = {x, x} << sh;
      case (FnClass)
         FN_LUI:   op_res = {y[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
         FN_SLT:   op_res = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
         FN_SGT:   op_res = {{(WIDTH-1){1'b0}}, ($signed(x) > $signed(y))};
         FN_ADD: begin
            op_res = sum;
            op_ovf = (x[WIDTH-1] == y_eff[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
         end
         FN_LOGIC: begin
            case (LogicFn)
               2'b00:   op_res = x & y;
               2'b01:   op_res = x | y;
               2'b10:   op_res = x ^ y;
               default: op_res = ~(x | y);
            endcase
         end
         FN_SHIFT: begin
            case (ShiftFn)
               2'b00:   op_res = sh_big ? '0 : (x << sh);
               2'b01:   op_res = sh_big ? '0 : (x >> sh);
               2'b10:   op_res = sh_big ? {WIDTH{x[WIDTH-1]}} : $unsigned($signed(x) >>> sh);
               default: op_res = rot2[2*WIDTH-1:WIDTH];
            endcase
         end
         FN_HAM:   op_res = pop;
         default:  op_res = '0;   // multiply disabled: zero result, latency 1
      endcase
   end

   // One shift-add step: add multiplicand when the multiplier LSB is set, then
   // shift the {carry, hi, lo} product register right by one.
   always_comb begin
      step_sum = {1'b0, mhi_q} + {1'b0, (mlo_q[0] ? mcand_q : {WIDTH{1'b0}})};
      step_hi  = step_sum[WIDTH:1];
      step_lo  = {step_sum[0], mlo_q[WIDTH-1:1]};
   end

   // Next-state logic for the control FSM and all datapath registers.
   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      ovf_d    = ovf_q;
      mcand_d  = mcand_q;
      mhi_d    = mhi_q;
      mlo_d    = mlo_q;
      cnt_d    = cnt_q;
      if (accept) begin
         if (is_mul) begin
            state_d = S_BUSY;
            mcand_d = x;
            mhi_d   = '0;
            mlo_d   = y;
            cnt_d   = '0;
         end else begin
            state_d  = S_DONE;
            result_d = op_res;
            ovf_d    = op_ovf;
         end
      end else begin
         case (state_q)
            S_BUSY: begin
               mhi_d = step_hi;
               mlo_d = step_lo;
               cnt_d = cnt_q + SHW'(1);
               if (cnt_q == LAST_CNT) begin
                  state_d  = S_DONE;
                  cnt_d    = '0;
                  result_d = step_lo;
                  ovf_d    = |step_hi;
               end
            end
            S_DONE: begin
               if (out_ready) state_d = S_IDLE;
            end
            default: state_d = state_q;
         endcase
      end
   end

   // State and datapath registers; reset discards any in-flight op.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         result_q <= '0;
         ovf_q    <= 1'b0;
         mcand_q  <= '0;
         mhi_q    <= '0;
         mlo_q    <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         ovf_q    <= ovf_d;
         mcand_q  <= mcand_d;
         mhi_q    <= mhi_d;
         mlo_q    <= mlo_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed test of alu_seq at WIDTH=32 and WIDTH=8.
// Expected {overflow, result} pairs go into a queue when an op is driven and
// are popped when the DUT presents out_valid.
module tb_alu_seq;

   logic clk;
   logic rst;

   // 32-bit instance signals
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [31:0] x, y, alu_res;
   logic        add_sub, const_var, ovf;
   logic [1:0]  logic_fn, shift_fn;
   logic [2:0]  fn_class;

   // 8-bit instance signals
   logic        in_valid8, in_ready8, out_valid8, out_ready8;
   logic [7:0]  x8, y8, alu_res8;
   logic        add_sub8, const_var8, ovf8;
   logic [1:0]  logic_fn8, shift_fn8;
   logic [2:0]  fn_class8;

   logic [32:0] exp_q[$];
   logic [8:0]  exp8_q[$];

   int total;
   int passed;

   alu_seq #(.WIDTH(32), .MUL_EN(1'b1)) dut32 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .x(x), .y(y), .add_sub(add_sub), .ConstVar(const_var),
      .LogicFn(logic_fn), .ShiftFn(shift_fn), .FnClass(fn_class),
      .out_valid(out_valid), .out_ready(out_ready),
      .ALU_result(alu_res), .Overflow(ovf)
   );

   alu_seq #(.WIDTH(8), .MUL_EN(1'b1)) dut8 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid8), .in_ready(in_ready8),
      .x(x8), .y(y8), .add_sub(add_sub8), .ConstVar(const_var8),
      .LogicFn(logic_fn8), .ShiftFn(shift_fn8), .FnClass(fn_class8),
      .out_valid(out_valid8), .out_ready(out_ready8),
      .ALU_result(alu_res8), .Overflow(ovf8)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
   endtask

   // Drive one op on the 32-bit DUT (called at a negedge), hold until accepted.
   task automatic send32(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                         input logic as, input logic cv, input logic [1:0] lf,
                         input logic [1:0] sf, input logic [32:0] expv);
      int guard;
      in_valid = 1'b1; fn_class = fn; x = a; y = b;
      add_sub = as; const_var = cv; logic_fn = lf; shift_fn = sf;
      exp_q.push_back(expv);
      #1;
      guard = 0;
      while (!in_ready && guard < 200) begin
         @(negedge clk); #1; guard++;
      end
      if (guard >= 200) check("send32_accept_timeout", {63'd0, in_ready}, 64'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Wait for the 32-bit result (starting one cycle after accept), compare, consume.
   task automatic recv32(input string tag, input int exp_lat);
      int n;
      logic [32:0] e;
      n = 1;
      while (!out_valid && n < 100) begin
         @(negedge clk); n++;
      end
      check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
      check({tag, "_latency"}, 64'(n), 64'(exp_lat));
      e = exp_q.pop_front();
      check({tag, "_result"}, {32'd0, alu_res}, {32'd0, e[31:0]});
      check({tag, "_ovf"}, {63'd0, ovf}, {63'd0, e[32]});
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send8(input logic [2:0] fn, input logic [7:0] a, input logic [7:0] b,
                        input logic as, input logic [8:0] expv);
      int guard;
      in_valid8 = 1'b1; fn_class8 = fn; x8 = a; y8 = b;
      add_sub8 = as; const_var8 = 1'b0; logic_fn8 = 2'b00; shift_fn8 = 2'b00;
      exp8_q.push_back(expv);
      #1;
      guard = 0;
      while (!in_ready8 && guard < 200) begin
         @(negedge clk); #1; guard++;
      end
      if (guard >= 200) check("send8_accept_timeout", {63'd0, in_ready8}, 64'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid8 = 1'b0;
   endtask

   task automatic recv8(input string tag, input int exp_lat);
      int n;
      logic [8:0] e;
      n = 1;
      while (!out_valid8 && n < 100) begin
         @(negedge clk); n++;
      end
      check({tag, "_valid"}, {63'd0, out_valid8}, 64'd1);
      check({tag, "_latency"}, 64'(n), 64'(exp_lat));
      e = exp8_q.pop_front();
      check({tag, "_result"}, {56'd0, alu_res8}, {56'd0, e[7:0]});
      check({tag, "_ovf"}, {63'd0, ovf8}, {63'd0, e[8]});
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic [32:0] e;
      logic [31:0] ham_x;
      total = 0; passed = 0;
      rst = 1'b1;
      in_valid = 1'b0; out_ready = 1'b1; x = '0; y = '0;
      add_sub = 1'b0; const_var = 1'b0; logic_fn = 2'b00; shift_fn = 2'b00; fn_class = 3'b000;
      in_valid8 = 1'b0; out_ready8 = 1'b1; x8 = '0; y8 = '0;
      add_sub8 = 1'b0; const_var8 = 1'b0; logic_fn8 = 2'b00; shift_fn8 = 2'b00; fn_class8 = 3'b000;

      // reset state
      repeat (2) @(negedge clk);
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_result", {32'd0, alu_res}, 64'd0);
      check("rst_ovf", {63'd0, ovf}, 64'd0);
      check("rst_in_ready", {63'd0, in_ready}, 64'd1);
      check("rst_in_ready8", {63'd0, in_ready8}, 64'd1);
      rst = 1'b0;
      @(negedge clk);

      // add/sub with signed overflow
      send32(3'b011, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 2'b00, 2'b00, {1'b1, 32'h8000_0000});
      recv32("add_ovf", 1);
      send32(3'b011, 32'd0, 32'd1, 1'b1, 1'b0, 2'b00, 2'b00, {1'b0, 32'hFFFF_FFFF});
      recv32("sub", 1);

      // saturating / rotating shifts
      send32(3'b101, 32'd1, 32'd32, 1'b0, 1'b0, 2'b00, 2'b00, {1'b0, 32'd0});
      recv32("sll_sat", 1);
      send32(3'b101, 32'h8000_0000, 32'd40, 1'b0, 1'b0, 2'b00, 2'b10, {1'b0, 32'hFFFF_FFFF});
      recv32("sra_sat", 1);
      send32(3'b101, 32'h8000_0001, 32'd36, 1'b0, 1'b0, 2'b00, 2'b11, {1'b0, 32'h0000_0018});
      recv32("rol_mod", 1);
      send32(3'b101, 32'h8000_0000, 32'd31, 1'b0, 1'b0, 2'b00, 2'b01, {1'b0, 32'd1});
      recv32("srl_31", 1);
      send32(3'b101, 32'd3, 32'd100, 1'b0, 1'b1, 2'b00, 2'b00, {1'b0, 32'd6});
      recv32("sll_const1", 1);

      // compares and logic
      send32(3'b001, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 2'b00, 2'b00, {1'b0, 32'd1});
      recv32("slt", 1);
      send32(3'b010, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 2'b00, 2'b00, {1'b0, 32'd0});
      recv32("sgt", 1);
      send32(3'b100, 32'h0F0F_0F0F, 32'h00FF_00FF, 1'b0, 1'b0, 2'b11, 2'b00, {1'b0, 32'hF000_F000});
      recv32("nor", 1);
      send32(3'b100, 32'h0F0F_0F0F, 32'h00FF_00FF, 1'b0, 1'b0, 2'b10, 2'b00, {1'b0, 32'h0FF0_0FF0});
      recv32("xor", 1);

      // iterative multiply
      send32(3'b111, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0, 2'b00, 2'b00, {1'b1, 32'd0});
      check("mul_busy_in_ready", {63'd0, in_ready}, 64'd0);
      recv32("mul_ovf", 33);
      send32(3'b111, 32'd1234, 32'd5678, 1'b0, 1'b0, 2'b00, 2'b00, {1'b0, 32'd7006652});
      recv32("mul_small", 33);

      // backpressure then back-to-back LUI
      out_ready = 1'b0;
      ham_x = 32'hF0F0_000F;
      send32(3'b110, ham_x, 32'd0, 1'b0, 1'b0, 2'b00, 2'b00, {1'b0, 32'd12});
      for (int i = 0; i < 5; i++) begin
         check("hold_valid", {63'd0, out_valid}, 64'd1);
         check("hold_result", {32'd0, alu_res}, {32'd0, exp_q[0][31:0]});
         check("hold_in_ready", {63'd0, in_ready}, 64'd0);
         @(negedge clk);
      end
      e = exp_q.pop_front();
      check("ham_result", {32'd0, alu_res}, {32'd0, e[31:0]});
      out_ready = 1'b1;
      send32(3'b000, 32'h1234_5678, 32'h0000_ABCD, 1'b0, 1'b0, 2'b00, 2'b00, {1'b0, 32'hABCD_0000});
      recv32("lui_b2b", 1);

      // asynchronous reset in the middle of a multiply
      send32(3'b111, 32'd3, 32'd5, 1'b0, 1'b0, 2'b00, 2'b00, {1'b0, 32'd15});
      repeat (9) @(negedge clk);
      check("midmul_busy", {63'd0, in_ready}, 64'd0);
      #2 rst = 1'b1;
      #1;
      check("midmul_rst_valid", {63'd0, out_valid}, 64'd0);
      check("midmul_rst_result", {32'd0, alu_res}, 64'd0);
      check("midmul_rst_in_ready", {63'd0, in_ready}, 64'd1);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      send32(3'b011, 32'd10, 32'd5, 1'b0, 1'b0, 2'b00, 2'b00, {1'b0, 32'd15});
      recv32("add_after_rst", 1);

      // 8-bit instance
      send8(3'b011, 8'h7F, 8'h01, 1'b0, {1'b1, 8'h80});
      recv8("w8_add_ovf", 1);
      send8(3'b110, 8'hFF, 8'h00, 1'b0, {1'b0, 8'd8});
      recv8("w8_ham", 1);
      send8(3'b111, 8'd16, 8'd16, 1'b0, {1'b1, 8'd0});
      recv8("w8_mul", 9);
      send8(3'b000, 8'h55, 8'h0C, 1'b0, {1'b0, 8'hC0});
      recv8("w8_lui", 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
